axi_lite_master: RTL and testbench

- AXI4-Lite initiator. Converts a simple one-outstanding command/response interface into AXI4-Lite read/write transactions.
- Counterpart of the team's AXI-Lite slave blocks (e.g. demo_part1). Drives their aximl_* channels in benches and in integrated designs.
- One transaction in flight at a time. Fixed 32-bit data bus.

---
 rtl/axi_lite_pkg.sv | 24 ++
 rtl/axi_lite_master.sv | 181 ++++++++++++++++++
 tb/tb_axi_lite_master.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, bus widths and the initiator FSM encoding.
package axi_lite_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_RSP     = 3'd5,
    ST_HALT    = 3'd6
  } mst_state_t;

endpackage

// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: one-outstanding command/response port to AXI-Lite read/write channels.
// Optional handshake watchdog enabled by defining AXI_LITE_MASTER_TIMEOUT_EN.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  i_axi_clk,
  input  logic                  i_axi_rst,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_wr,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0]     i_cmd_wdata,
  input  logic [STRB_W-1:0]     i_cmd_wstrb,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_W-1:0]     o_rsp_rdata,
  output logic [1:0]            o_rsp_resp,
  output logic                  o_awvalid,
  output logic [ADDR_WIDTH-1:0] o_awaddr,
  input  logic                  i_awready,
  output logic                  o_wvalid,
  input  logic                  i_wready,
  output logic [DATA_W-1:0]     o_wdata,
  output logic [STRB_W-1:0]     o_wstrb,
  input  logic                  i_bvalid,
  output logic                  o_bready,
  input  logic [1:0]            i_bresp,
  output logic                  o_arvalid,
  input  logic                  i_arready,
  output logic [ADDR_WIDTH-1:0] o_araddr,
  input  logic                  i_rvalid,
  output logic                  o_rready,
  input  logic [1:0]            i_rresp,
  input  logic [DATA_W-1:0]     i_rdata
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
  ,
  output logic                  o_timeout
`endif
);

  mst_state_t            r_state;
  mst_state_t            w_next;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_arvalid;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic [DATA_W-1:0]     r_rdata;
  logic [1:0]            r_resp;
  logic                  w_accept;
  logic                  w_aw_done;
  logic                  w_w_done;
  logic                  w_tmo;
  logic                  w_tmo_fire;
  logic                  w_halt_en;

  assign w_accept  = (r_state == ST_IDLE) && i_cmd_valid;
  // A channel counts as done once its valid has dropped or it handshakes this cycle.
  assign w_aw_done = !r_awvalid || i_awready;
  assign w_w_done  = !r_wvalid  || i_wready;

  assign o_awvalid   = r_awvalid;
  assign o_wvalid    = r_wvalid;
  assign o_arvalid   = r_arvalid;
  assign o_awaddr    = r_addr;
  assign o_araddr    = r_addr;
  assign o_wdata     = r_wdata;
  assign o_wstrb     = r_wstrb;
  assign o_rsp_rdata = r_rdata;
  assign o_rsp_resp  = r_resp;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;
  logic             w_counting;

  assign w_counting = (r_state == ST_WR_REQ) || (r_state == ST_WR_RESP) ||
                      (r_state == ST_RD_REQ) || (r_state == ST_RD_DATA);
  assign w_tmo      = w_counting && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_halt_en  = r_timeout;
  assign o_timeout  = r_timeout;

  always_ff @(posedge i_axi_clk or posedge i_axi_rst) begin
    if (i_axi_rst) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_next != r_state) r_cnt <= '0;
      else if (w_counting)   r_cnt <= r_cnt + 1'b1;
      if (w_tmo_fire) r_timeout <= 1'b1;
    end
  end
`else
  assign w_tmo     = 1'b0;
  assign w_halt_en = 1'b0;
`endif

  always_ff @(posedge i_axi_clk or posedge i_axi_rst) begin
    if (i_axi_rst) r_state <= ST_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_tmo_fire  = 1'b0;
    o_cmd_ready = 1'b0;
    o_bready    = 1'b0;
    o_rready    = 1'b0;
    o_rsp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_cmd_ready = !i_axi_rst;
        if (i_cmd_valid) w_next = i_cmd_wr ? ST_WR_REQ : ST_RD_REQ;
      end
      ST_WR_REQ:  if (w_aw_done && w_w_done) w_next = ST_WR_RESP;
      ST_WR_RESP: begin
        o_bready = 1'b1;
        if (i_bvalid) w_next = ST_RSP;
      end
      ST_RD_REQ:  if (i_arready) w_next = ST_RD_DATA;
      ST_RD_DATA: begin
        o_rready = 1'b1;
        if (i_rvalid) w_next = ST_RSP;
      end
      ST_RSP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) w_next = w_halt_en ? ST_HALT : ST_IDLE;
      end
      default: w_next = r_state;
    endcase
    // A handshake completing in the same cycle as the watchdog expiry takes priority.
    if (w_tmo && (w_next == r_state)) begin
      w_next     = ST_RSP;
      w_tmo_fire = 1'b1;
    end
  end

  always_ff @(posedge i_axi_clk or posedge i_axi_rst) begin
    if (i_axi_rst) begin
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_arvalid <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdata   <= '0;
      r_resp    <= RESP_OKAY;
    end else begin
      if (w_accept) begin
        r_addr    <= i_cmd_addr;
        r_wdata   <= i_cmd_wdata;
        r_wstrb   <= i_cmd_wstrb;
        r_awvalid <= i_cmd_wr;
        r_wvalid  <= i_cmd_wr;
        r_arvalid <= !i_cmd_wr;
      end else begin
        // Valids stay up until their own handshake, even after a watchdog expiry.
        if (i_awready) r_awvalid <= 1'b0;
        if (i_wready)  r_wvalid  <= 1'b0;
        if (i_arready) r_arvalid <= 1'b0;
      end
      if (w_tmo_fire) begin
        r_rdata <= '0;
        r_resp  <= RESP_DECERR;
      end else if ((r_state == ST_WR_RESP) && i_bvalid) begin
        r_rdata <= '0;
        r_resp  <= i_bresp;
      end else if ((r_state == ST_RD_DATA) && i_rvalid) begin
        r_rdata <= i_rdata;
        r_resp  <= i_rresp;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: AXI-Lite slave model with programmable ready delays and
// a response scoreboard; the watchdog case runs when AXI_LITE_MASTER_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_axi_lite_master;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_wr = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_ready = 1'b0;
  logic        cmd_ready, rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        awvalid, wvalid, arvalid, bready, rready;
  logic        awready = 1'b0, wready = 1'b0, arready = 1'b0, bvalid = 1'b0, rvalid = 1'b0;
  logic [31:0] awaddr, araddr, wdata;
  logic [31:0] rdata = '0;
  logic [3:0]  wstrb;
  logic [1:0]  bresp = '0, rresp = '0;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
  logic        timeout;
`endif

  always #5 clk = ~clk;

  axi_lite_master #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(1024)) dut (
    .i_axi_clk(clk), .i_axi_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_wr(cmd_wr),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_wstrb(cmd_wstrb),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata), .o_rsp_resp(rsp_resp),
    .o_awvalid(awvalid), .o_awaddr(awaddr), .i_awready(awready),
    .o_wvalid(wvalid), .i_wready(wready), .o_wdata(wdata), .o_wstrb(wstrb),
    .i_bvalid(bvalid), .o_bready(bready), .i_bresp(bresp),
    .o_arvalid(arvalid), .i_arready(arready), .o_araddr(araddr),
    .i_rvalid(rvalid), .o_rready(rready), .i_rresp(rresp), .i_rdata(rdata)
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    , .o_timeout(timeout)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  // slave configuration and observation
  int          aw_dly = 0, w_dly = 0, r_dly = 0, hold = 0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  int          aw_cnt = 0, w_cnt = 0, r_cnt = 0;
  bit          aw_seen = 0, w_seen = 0, r_pend = 0;
  int          n_aw = 0, n_w = 0, n_ar = 0, n_b = 0;
  int          aw_hs_cyc = 0, w_hs_cyc = 0, rsp_rise = 0, acc_cyc = 0;
  logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
  logic [3:0]  cap_wstrb = '0;
  logic        p_awvalid = 0, p_wvalid = 0, p_arvalid = 0, p_bready = 0, p_rready = 0;
  logic        p_rsp_valid = 0, p_rsp_ready = 0;
  logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0, p_rsp_rdata = '0;
  logic [3:0]  p_wstrb = '0;
  logic [1:0]  p_rsp_resp = '0;
  logic [31:0] mem [logic [31:0]];
  exp_t        exp_q[$];
  exp_t        e;
  logic [31:0] word;

  // Slave model: every decision is made on the falling edge from values that held at the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; rsp_ready = 0;
        aw_cnt = 0; w_cnt = 0; r_cnt = 0; aw_seen = 0; w_seen = 0; r_pend = 0;
        p_awvalid = 0; p_wvalid = 0; p_arvalid = 0; p_bready = 0; p_rready = 0;
        p_rsp_valid = 0; p_rsp_ready = 0;
      end else begin
        if (p_awvalid && awvalid) check("awaddr_stable", awaddr, p_awaddr);
        if (p_wvalid && wvalid)   check("wdata_stable", wdata, p_wdata);
        if (p_awvalid && awready) begin n_aw++; aw_seen = 1; cap_awaddr = p_awaddr; aw_hs_cyc = cyc; end
        if (p_wvalid && wready) begin
          n_w++; w_seen = 1; cap_wdata = p_wdata; cap_wstrb = p_wstrb; w_hs_cyc = cyc;
        end
        if (p_arvalid && arready) begin n_ar++; cap_araddr = p_araddr; r_pend = 1; r_cnt = 0; end
        if (bvalid && p_bready) begin bvalid = 0; n_b++; end
        if (rvalid && p_rready) rvalid = 0;
        if (p_rsp_valid && p_rsp_ready) begin
          if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("rsp_rdata", p_rsp_rdata, e.rdata);
            check("rsp_resp", p_rsp_resp, e.resp);
          end
        end
        if (aw_seen && w_seen && !bvalid) begin
          word = mem.exists(cap_awaddr) ? mem[cap_awaddr] : 32'h0;
          for (int i = 0; i < 4; i++) if (cap_wstrb[i]) word[8*i +: 8] = cap_wdata[8*i +: 8];
          mem[cap_awaddr] = word;
          bvalid = 1; bresp = cfg_bresp; aw_seen = 0; w_seen = 0;
        end
        if (r_pend) begin
          if (r_cnt >= r_dly) begin
            rvalid = 1; rresp = cfg_rresp; r_pend = 0;
            rdata = mem.exists(cap_araddr) ? mem[cap_araddr] : 32'h0;
          end else r_cnt++;
        end
        awready = awvalid && (aw_cnt >= aw_dly);
        aw_cnt  = awvalid ? aw_cnt + 1 : 0;
        wready  = wvalid && (w_cnt >= w_dly);
        w_cnt   = wvalid ? w_cnt + 1 : 0;
        arready = arvalid;
        if (rsp_valid && !p_rsp_valid) rsp_rise = cyc;
        rsp_ready = (hold == 0);
        if (rsp_valid && hold > 0) hold--;
        p_awvalid = awvalid; p_awaddr = awaddr; p_wvalid = wvalid; p_wdata = wdata; p_wstrb = wstrb;
        p_arvalid = arvalid; p_araddr = araddr; p_bready = bready; p_rready = rready;
        p_rsp_valid = rsp_valid; p_rsp_ready = rsp_ready; p_rsp_rdata = rsp_rdata; p_rsp_resp = rsp_resp;
      end
    end
  end

  task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] er, input logic [1:0] eresp);
    int n = 0;
    exp_t x;
    n_aw = 0; n_w = 0; n_ar = 0; n_b = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    check("cmd_accept_wait", (n < 50), 1);
    cmd_valid = 1; cmd_wr = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    acc_cyc = cyc;
    x.rdata = er; x.resp = eresp;
    exp_q.push_back(x);
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin @(negedge clk); n++; end
    check("rsp_wait", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("rst_ctrl", {cmd_ready, awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
    check("rst_addr", {awaddr, araddr}, 0);
    check("rst_data", {wdata, wstrb, rsp_resp}, 0);
    check("rst_rdata", rsp_rdata, 0);
    rst = 0;
    @(negedge clk);
    check("idle_cmd_ready", cmd_ready, 1);

    // zero-wait write and read-back
    issue(1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00);
    wait_done(50);
    check("wr_n_aw", n_aw, 1);
    check("wr_n_w", n_w, 1);
    check("wr_aw_w_same_cycle", aw_hs_cyc, w_hs_cyc);
    check("wr_awaddr", cap_awaddr, 32'h10);
    check("wr_wdata", cap_wdata, 32'hDEADBEEF);
    check("wr_wstrb", cap_wstrb, 4'hF);
    check("wr_latency", rsp_rise - acc_cyc, 3);
    issue(0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00);
    wait_done(50);
    check("rd_araddr", cap_araddr, 32'h10);
    check("rd_n_ar", n_ar, 1);
    check("rd_latency", rsp_rise - acc_cyc, 3);

    // AW/W handshake ordering: W first, AW first, simultaneous
    for (int i = 0; i < 3; i++) begin
      aw_dly = (i == 0) ? 3 : ((i == 1) ? 0 : 2);
      w_dly  = (i == 0) ? 0 : ((i == 1) ? 3 : 2);
      issue(1, 32'h20 + 32'(4 * i), 32'hA5A50000 + 32'(i), 4'hF, 32'h0, 2'b00);
      wait_done(50);
      check("ord_n_aw", n_aw, 1);
      check("ord_n_w", n_w, 1);
      check("ord_n_b", n_b, 1);
      check("ord_wdata", cap_wdata, 32'hA5A50000 + 32'(i));
      check("ord_awaddr", cap_awaddr, 32'h20 + 32'(4 * i));
      check("ord_skew", aw_hs_cyc - w_hs_cyc, aw_dly - w_dly);
    end
    aw_dly = 0; w_dly = 0;

    // partial strobe write then read-back
    issue(1, 32'h10, 32'h11112222, 4'h3, 32'h0, 2'b00);
    wait_done(50);
    issue(0, 32'h10, 32'h0, 4'h0, 32'hDEAD2222, 2'b00);
    wait_done(50);

    // error responses pass through unchanged
    cfg_bresp = 2'b10;
    issue(1, 32'h30, 32'h12345678, 4'hF, 32'h0, 2'b10);
    wait_done(50);
    check("slverr_idle_ready", cmd_ready, 1);
    cfg_bresp = 2'b00; cfg_rresp = 2'b11;
    issue(0, 32'h30, 32'h0, 4'h0, 32'h12345678, 2'b11);
    wait_done(50);
    check("decerr_idle_ready", cmd_ready, 1);
    cfg_rresp = 2'b00;

    // response back-pressure: output held, new command ignored
    hold = 5;
    issue(0, 32'h20, 32'h0, 4'h0, 32'hA5A50000, 2'b00);
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    check("hold_rsp_seen", rsp_valid, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        cmd_valid = 1; cmd_wr = 1; cmd_addr = 32'h40; cmd_wdata = 32'hFFFF0000; cmd_wstrb = 4'hF;
      end
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_cmd_ready", cmd_ready, 0);
      check("hold_rdata", rsp_rdata, 32'hA5A50000);
    end
    cmd_valid = 0;
    wait_done(50);
    check("hold_no_write", n_aw, 0);
    check("hold_one_read", n_ar, 1);

    // asynchronous reset while waiting for read data
    r_dly = 1000;
    issue(0, 32'h10, 32'h0, 4'h0, 32'hDEAD2222, 2'b00);
    n = 0;
    while (!rready && n < 20) begin @(negedge clk); n++; end
    check("abort_in_rd_data", rready, 1);
    rst = 1;
    #1;
    check("abort_rready", rready, 0);
    check("abort_arvalid", arvalid, 0);
    check("abort_ctrl", {cmd_ready, rsp_valid, awvalid, wvalid, bready}, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 0; r_dly = 0;
    @(negedge clk);
    check("abort_cmd_ready", cmd_ready, 1);
    issue(0, 32'h10, 32'h0, 4'h0, 32'hDEAD2222, 2'b00);
    wait_done(50);

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    check("tmo_clear", timeout, 0);
    aw_dly = 100000;
    issue(1, 32'h50, 32'hCAFEF00D, 4'hF, 32'h0, 2'b11);
    wait_done(1200);
    check("tmo_flag", timeout, 1);
    check("tmo_aw_pending", awvalid, 1);
    repeat (3) begin
      @(negedge clk);
      check("tmo_halt_ready", cmd_ready, 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
